grf_scoreboard: RTL and testbench
=================================

# grf_scoreboard

Register-busy scoreboard that schedules access to the 32×32 general register file (GRF) in the pipelined CPU. It records which GRF registers have an in-flight write and holds the issue stage until every source operand is valid and the destination has no outstanding write. Writeback releases registers. The block sits beside the GRF, between the decode/issue stage and the writeback stage, and produces the issue stall.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width, equal to clog2(NREG).
- MAX_PENDING, 8, maximum number of outstanding writes, range 1..NREG-1.
- WB_BYPASS, 1, when 1 a same-cycle writeback releases its register for the issue check.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all outstanding writes (pipeline squash).
- iss_valid  in  1  issue stage presents an instruction.
- iss_rs  in  AW  source register 1.
- iss_rs_used  in  1  rs is read.
- iss_rt  in  AW  source register 2.
- iss_rt_used  in  1  rt is read.
- iss_rd  in  AW  destination register.
- iss_rd_we  in  1  instruction writes rd.
- iss_ready  out  1  instruction may issue this cycle.
- wb_valid  in  1  writeback stage writes the GRF this cycle.
- wb_addr  in  AW  writeback register.
- busy_mask  out  NREG  registered busy bit per register; bit 0 is always 0.
- pending_cnt  out  clog2(MAX_PENDING+1)  number of set busy bits.
- err_spurious_wb  out  1  sticky flag: a writeback hit a non-busy register.

## Operation
- An issue is accepted when iss_valid && iss_ready. Writeback has no handshake and is always consumed.
- Effective busy bit for register r (eff(r)): busy_mask[r], cleared for r = wb_addr when WB_BYPASS=1 and a valid, non-zero writeback targets r.
- iss_ready = !flush && !(iss_rs_used && eff(iss_rs)) && !(iss_rt_used && eff(iss_rt)) && !(iss_rd_we && eff(iss_rd)) && slot_free.
  - slot_free = (pending_cnt − wb_release) < MAX_PENDING, or the issue does not set a busy bit.
  - wb_release counts only when WB_BYPASS=1.
- Set rule: an accepted issue with iss_rd_we and iss_rd≠0 sets busy[iss_rd].
- Clear rule: a wb_valid with wb_addr≠0 whose register is busy clears that bit.
- If wb_valid targets a non-busy, non-zero register: ignore it, leave pending_cnt unchanged, set err_spurious_wb.
- A writeback to register 0 is ignored silently.
- If an issue sets and a writeback clears the same register in the same cycle, the set wins: the bit stays 1 and pending_cnt is unchanged.
- pending_cnt_next = pending_cnt + set − clear. It never exceeds MAX_PENDING and never goes below 0.
- Flush takes priority over issue and writeback in the same cycle.
  - busy_mask and pending_cnt become 0.
  - A spurious-writeback check still updates err_spurious_wb.
- err_spurious_wb is cleared only by reset.

## Timing
- Reset: busy_mask=0, pending_cnt=0, err_spurious_wb=0. iss_ready evaluates combinationally to 1 while reset is held and flush=0.
- iss_ready is combinational from the registered state plus the current inputs. busy_mask and pending_cnt update on the edge following the event (1-cycle latency).
- Read-after-write (RAW) on a busy source:
  - With WB_BYPASS=1, the stall ends in the writeback cycle itself.
  - With WB_BYPASS=0, the stall ends one cycle after writeback.
- Reset asserted mid-operation discards all state at the next edge, just like flush, and also clears err_spurious_wb.

## Structure
- Shared package grf_pkg holds:
  - NREG, AW, REG_ZERO;
  - typedef reg_addr_t (AW bits);
  - typedef reg_mask_t (NREG bits).
- One natural sub-module, grf_sb_hazard: purely combinational. It computes eff() and iss_ready from busy_mask, the issue inputs and the writeback inputs.
- The top level holds the busy register, the counter and the error flag.

## Test plan
- Reset, then issue rd=8 with rs/rt unused → iss_ready=1. Next cycle busy_mask=0x100, pending_cnt=1.
- RAW stall:
  - Stimulus: busy[8]=1, issue rs=8; wb_addr=8 three cycles later.
  - WB_BYPASS=1: iss_ready=0 for 3 cycles, 1 in the wb cycle.
  - WB_BYPASS=0: iss_ready stays 0 until the cycle after wb.
- Capacity:
  - Issue 8 writes to r1..r8 → pending_cnt=8; a 9th issue (rd=9) gives iss_ready=0.
  - Same cycle as wb r1 with WB_BYPASS=1 → iss_ready=1 and pending_cnt stays 8.
- Same-cycle set/clear: busy[5]=1; issue rd=5 with wb_addr=5 in the same cycle → busy[5]=1 and pending_cnt unchanged.
- Zero register and spurious writeback:
  - Issue rd=0 → busy_mask unchanged.
  - wb_addr=0 → no error.
  - wb_addr=12 while not busy → err_spurious_wb=1, sticky until reset.
- Flush: with busy_mask=0x0000_F0F0, assert flush together with iss_valid and rd=3 → iss_ready=0. Next cycle busy_mask=0, pending_cnt=0.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared definitions for the general register file and its scoreboard.
package grf_pkg;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [NREG-1:0] reg_mask_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/grf_sb_hazard.sv
// Combinational issue check: effective busy bits (with optional writeback
// bypass), operand/destination hazards and outstanding-write capacity.
module grf_sb_hazard
  import grf_pkg::*;
#(
  parameter int NREG        = grf_pkg::NREG,
  parameter int AW          = grf_pkg::AW,
  parameter int MAX_PENDING = 8,
  parameter int WB_BYPASS   = 1,
  parameter int CW          = $clog2(MAX_PENDING + 1)
) (
  input  logic [NREG-1:0] busy_mask,
  input  logic [CW-1:0]   pending_cnt,
  input  logic            flush,
  input  logic [AW-1:0]   iss_rs,
  input  logic            iss_rs_used,
  input  logic [AW-1:0]   iss_rt,
  input  logic            iss_rt_used,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_rd_we,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  output logic            wb_hit,
  output logic            iss_ready
);
  logic [NREG-1:0] eff;
  logic            rel;
  logic            sets;
  logic [CW:0]     cnt_eff;
  logic            slot_free;

  // Bypass lets a same-cycle writeback release its register for this check.
  always_comb begin
    wb_hit  = wb_valid && (wb_addr != AW'(REG_ZERO)) && busy_mask[wb_addr];
    rel     = (WB_BYPASS != 0) && wb_hit;
    eff     = busy_mask;
    if (rel) eff[wb_addr] = 1'b0;
    sets    = iss_rd_we && (iss_rd != AW'(REG_ZERO));
    cnt_eff = {1'b0, pending_cnt} - {{CW{1'b0}}, rel};
    slot_free = !sets || (cnt_eff < (CW+1)'(MAX_PENDING));
    iss_ready = !flush
             && !(iss_rs_used && eff[iss_rs])
             && !(iss_rt_used && eff[iss_rt])
             && !(iss_rd_we   && eff[iss_rd])
             && slot_free;
  end
endmodule

// File: rtl/grf_scoreboard.sv
// GRF busy scoreboard: tracks in-flight writes, stalls issue on hazards,
// releases registers on writeback and flags writebacks to idle registers.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int NREG        = grf_pkg::NREG,
  parameter int AW          = grf_pkg::AW,
  parameter int MAX_PENDING = 8,
  parameter int WB_BYPASS   = 1,
  localparam int CW         = $clog2(MAX_PENDING + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs,
  input  logic            iss_rs_used,
  input  logic [AW-1:0]   iss_rt,
  input  logic            iss_rt_used,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_rd_we,
  output logic            iss_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  output logic [NREG-1:0] busy_mask,
  output logic [CW-1:0]   pending_cnt,
  output logic            err_spurious_wb
);
  logic            wb_hit;
  logic            set;
  logic            inc;
  logic            dec;
  logic            spurious;
  logic [NREG-1:0] mask_next;
  logic [CW-1:0]   cnt_next;

  grf_sb_hazard #(
    .NREG(NREG), .AW(AW), .MAX_PENDING(MAX_PENDING), .WB_BYPASS(WB_BYPASS), .CW(CW)
  ) u_hazard (
    .busy_mask  (busy_mask),
    .pending_cnt(pending_cnt),
    .flush      (flush),
    .iss_rs     (iss_rs),
    .iss_rs_used(iss_rs_used),
    .iss_rt     (iss_rt),
    .iss_rt_used(iss_rt_used),
    .iss_rd     (iss_rd),
    .iss_rd_we  (iss_rd_we),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_hit     (wb_hit),
    .iss_ready  (iss_ready)
  );

  // Next mask/count. Counting bit transitions keeps pending_cnt equal to the
  // popcount when a set and a clear collide on one register (set wins).
  always_comb begin
    set       = iss_valid && iss_ready && iss_rd_we && (iss_rd != AW'(REG_ZERO));
    spurious  = wb_valid && (wb_addr != AW'(REG_ZERO)) && !busy_mask[wb_addr];
    inc       = set && !busy_mask[iss_rd];
    dec       = wb_hit && !(set && (iss_rd == wb_addr));
    mask_next = busy_mask;
    if (dec) mask_next[wb_addr] = 1'b0;
    if (set) mask_next[iss_rd]  = 1'b1;
    cnt_next  = pending_cnt;
    if (inc && !dec)      cnt_next = pending_cnt + CW'(1);
    else if (dec && !inc) cnt_next = pending_cnt - CW'(1);
  end

  // State registers; flush squashes outstanding writes but keeps error history.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_mask       <= '0;
      pending_cnt     <= '0;
      err_spurious_wb <= 1'b0;
    end else begin
      err_spurious_wb <= err_spurious_wb | spurious;
      if (flush) begin
        busy_mask   <= '0;
        pending_cnt <= '0;
      end else begin
        busy_mask   <= mask_next;
        pending_cnt <= cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard; a bypass instance and a no-bypass
// instance share stimulus, expected register state is queued per cycle.
module tb_grf_scoreboard;
  logic        clk = 1'b0;
  logic        reset, flush, iss_valid, iss_rs_used, iss_rt_used, iss_rd_we, wb_valid;
  logic [4:0]  iss_rs, iss_rt, iss_rd, wb_addr;
  logic        rdy, rdy_nb, err, err_nb;
  logic [31:0] mask, mask_nb;
  logic [3:0]  cnt, cnt_nb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] mask;
    logic [3:0]  cnt;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  grf_scoreboard #(.MAX_PENDING(8), .WB_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .iss_valid(iss_valid),
    .iss_rs(iss_rs), .iss_rs_used(iss_rs_used), .iss_rt(iss_rt), .iss_rt_used(iss_rt_used),
    .iss_rd(iss_rd), .iss_rd_we(iss_rd_we), .iss_ready(rdy), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .busy_mask(mask), .pending_cnt(cnt), .err_spurious_wb(err));

  grf_scoreboard #(.MAX_PENDING(8), .WB_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .flush(flush), .iss_valid(iss_valid),
    .iss_rs(iss_rs), .iss_rs_used(iss_rs_used), .iss_rt(iss_rt), .iss_rt_used(iss_rt_used),
    .iss_rd(iss_rd), .iss_rd_we(iss_rd_we), .iss_ready(rdy_nb), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .busy_mask(mask_nb), .pending_cnt(cnt_nb), .err_spurious_wb(err_nb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] m, input logic [3:0] c, input logic e);
    exp_t x;
    x.tag = tag; x.mask = m; x.cnt = c; x.err = e;
    exp_q.push_back(x);
  endtask

  // Advance one edge and compare registered outputs against the queued entry.
  task automatic tick();
    exp_t x;
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk({x.tag, ".mask"}, mask, x.mask);
      chk({x.tag, ".cnt"},  {28'd0, cnt}, {28'd0, x.cnt});
      chk({x.tag, ".err"},  {31'd0, err}, {31'd0, x.err});
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rd, input logic we,
                       input logic wv, input logic [4:0] wa, input logic fl);
    iss_valid = v; iss_rs = rs; iss_rs_used = rsu; iss_rt = 5'd0; iss_rt_used = 1'b0;
    iss_rd = rd; iss_rd_we = we; wb_valid = wv; wb_addr = wa; flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] m;
    reset = 1'b1;
    idle();
    chk("reset_ready", {31'd0, rdy}, 32'd1);
    tick(); tick();
    chk("reset_mask", mask, 32'd0);
    chk("reset_cnt", {28'd0, cnt}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    reset = 1'b0;

    // First issue: rd=8.
    drive(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("issue_r8_ready", {31'd0, rdy}, 32'd1);
    push("issue_r8", 32'h100, 4'd1, 1'b0);
    tick();

    // RAW on r8: three stalled cycles, then writeback.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk($sformatf("raw_stall%0d", i), {31'd0, rdy}, 32'd0);
      chk($sformatf("raw_stall_nb%0d", i), {31'd0, rdy_nb}, 32'd0);
      push($sformatf("raw_hold%0d", i), 32'h100, 4'd1, 1'b0);
      tick();
    end
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    chk("raw_wb_bypass", {31'd0, rdy}, 32'd1);
    chk("raw_wb_nobypass", {31'd0, rdy_nb}, 32'd0);
    push("raw_wb", 32'h0, 4'd0, 1'b0);
    tick();
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("raw_after_nobypass", {31'd0, rdy_nb}, 32'd1);
    chk("raw_after_nb_mask", mask_nb, 32'd0);
    push("raw_after", 32'h0, 4'd0, 1'b0);
    tick();

    // Capacity: fill r1..r8.
    m = 32'd0;
    for (int r = 1; r <= 8; r++) begin
      drive(1'b1, 5'd0, 1'b0, 5'(r), 1'b1, 1'b0, 5'd0, 1'b0);
      chk($sformatf("fill_r%0d_ready", r), {31'd0, rdy}, 32'd1);
      m[r] = 1'b1;
      push($sformatf("fill_r%0d", r), m, 4'(r), 1'b0);
      tick();
    end
    drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("full_r9_stall", {31'd0, rdy}, 32'd0);
    push("full_hold", 32'h1FE, 4'd8, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd1, 1'b0);
    chk("full_wb_r1_ready", {31'd0, rdy}, 32'd1);
    push("full_swap", 32'h3FC, 4'd8, 1'b0);
    tick();

    // Same-cycle set/clear on r5.
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    chk("rst2_mask", mask, 32'd0);
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    push("set_r5", 32'h20, 4'd1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
    chk("setclr_ready", {31'd0, rdy}, 32'd1);
    push("setclr_r5", 32'h20, 4'd1, 1'b0);
    tick();

    // Zero register and spurious writeback.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("rd0_ready", {31'd0, rdy}, 32'd1);
    push("rd0", 32'h20, 4'd1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    push("wb_r0", 32'h20, 4'd1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0);
    push("wb_spurious", 32'h20, 4'd1, 1'b1);
    tick();
    idle();
    push("err_sticky", 32'h20, 4'd1, 1'b1);
    tick();

    // Build 0xF0F0 then flush with a competing issue.
    m = 32'h20;
    foreach (m[r]) begin
      if (r inside {4, 6, 7, 12, 13, 14, 15}) begin
        drive(1'b1, 5'd0, 1'b0, 5'(r), 1'b1, 1'b0, 5'd0, 1'b0);
        m[r] = 1'b1;
        push($sformatf("build_r%0d", r), m, 4'($countones(m)), 1'b1);
        tick();
      end
    end
    drive(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1);
    chk("flush_ready", {31'd0, rdy}, 32'd0);
    push("flush", 32'h0, 4'd0, 1'b1);
    tick();

    // Reset clears the sticky flag; a spurious wb during flush still sets it.
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    chk("rst3_err", {31'd0, err}, 32'd0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    push("flush_spurious", 32'h0, 4'd0, 1'b1);
    tick();
    idle();
    tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
